angle_sampler: RTL

ANGLE_SAMPLER -- requirements
Module: angle_sampler

---
 rtl/angle_pkg.sv | 29 ++
 rtl/sync_edge.sv | 25 ++
 rtl/angle_sampler.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/angle_pkg.sv
// Shared definitions for the angle sampling subsystem: angle width, scheduler
// state encoding and the round-robin channel picker.
package angle_pkg;

    localparam int unsigned ANGLE_W = 12;

    typedef enum logic [2:0] {
        StIdle,
        StSelect,
        StRequest,
        StWait,
        StCapture,
        StNext
    } sched_state_e;

    // Lowest set mask bit at or above 'from', wrapping modulo 8. Unused upper
    // mask bits are zero, so the wrap also works for fewer than 8 channels.
    function automatic logic [2:0] pick_ch(input logic [7:0] mask, input logic [2:0] from);
        logic [2:0] idx;
        pick_ch = from;
        for (int i = 7; i >= 0; i--) begin
            idx = from + 3'(i);
            if (mask[idx]) begin
                pick_ch = idx;
            end
        end
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser with rising-edge detect for a level crossing from a
// slower or unrelated clock domain.
module sync_edge (
    input  logic clock,
    input  logic reset_n,
    input  logic din,
    output logic rise
);

    logic ff1_q;
    logic ff2_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ff1_q <= 1'b0;
            ff2_q <= 1'b0;
        end else begin
            ff1_q <= din;
            ff2_q <= ff1_q;
        end
    end

    assign rise = ff1_q & ~ff2_q;

endmodule

// File: rtl/angle_sampler.sv
// Round-robin scheduler that polls AS5600 encoders behind an I2C mux through
// the existing I2C engine and keeps per-channel angle, delta and status.
module angle_sampler
    import angle_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned DIV_W      = 7,
    parameter int unsigned SETTLE_CYC = 16,
    parameter int unsigned TMO_W      = 16
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic [NUM_CH-1:0]           ch_mask,
    output logic                        i2c_clk,
    output logic [2:0]                  mux_sel,
    output logic                        rd_req,
    input  logic                        rd_done,
    input  logic [ANGLE_W-1:0]          raw_angle,
    output logic [NUM_CH*ANGLE_W-1:0]   ch_angle,
    output logic [NUM_CH*ANGLE_W-1:0]   ch_delta,
    output logic [NUM_CH-1:0]           ch_valid,
    output logic [NUM_CH-1:0]           ch_timeout,
    output logic                        sample_stb,
    output logic [2:0]                  sample_ch
);

    localparam int unsigned SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
    localparam logic [SET_W-1:0] SET_ONE     = SET_W'(1);
    localparam logic [TMO_W-1:0] TMO_ONE     = TMO_W'(1);
    // One short of all-ones: the count is about to reach 2^TMO_W-1
    localparam logic [TMO_W-1:0] TMO_LAST    = {{(TMO_W-1){1'b1}}, 1'b0};
    localparam logic [DIV_W-1:0] DIV_ONE     = DIV_W'(1);

    logic [DIV_W-1:0] div_q;
    logic             done_rise;
    logic [7:0]       mask8;
    logic [2:0]       ptr_q;
    logic [2:0]       next_ch;
    logic [SET_W-1:0] settle_q;
    logic [TMO_W-1:0] tmo_q;
    sched_state_e     state_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_ONE;
        end
    end

    assign i2c_clk = div_q[DIV_W-1];

    sync_edge u_done_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .din     (rd_done),
        .rise    (done_rise)
    );

    assign mask8   = 8'(ch_mask);
    assign next_ch = pick_ch(mask8, ptr_q + 3'd1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            settle_q   <= '0;
            tmo_q      <= '0;
            mux_sel    <= '0;
            rd_req     <= 1'b0;
            sample_stb <= 1'b0;
            sample_ch  <= '0;
            ch_angle   <= '0;
            ch_delta   <= '0;
            ch_valid   <= '0;
            ch_timeout <= '0;
        end else begin
            sample_stb <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (enable && (|ch_mask)) begin
                        ptr_q    <= pick_ch(mask8, ptr_q);
                        mux_sel  <= pick_ch(mask8, ptr_q);
                        settle_q <= '0;
                        state_q  <= StSelect;
                    end
                end
                StSelect: begin
                    if (settle_q == SETTLE_LAST) begin
                        rd_req  <= 1'b1;
                        state_q <= StRequest;
                    end else begin
                        settle_q <= settle_q + SET_ONE;
                    end
                end
                StRequest: begin
                    // An edge seen here predates the request and is dropped
                    tmo_q   <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    if (done_rise) begin
                        rd_req  <= 1'b0;
                        state_q <= StCapture;
                    end else if (tmo_q == TMO_LAST) begin
                        rd_req  <= 1'b0;
                        state_q <= StNext;
                        for (int c = 0; c < NUM_CH; c++) begin
                            if (ptr_q == 3'(c)) begin
                                ch_timeout[c] <= 1'b1;
                                ch_valid[c]   <= 1'b0;
                            end
                        end
                    end else begin
                        tmo_q <= tmo_q + TMO_ONE;
                    end
                end
                StCapture: begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (ptr_q == 3'(c)) begin
                            ch_angle[c*ANGLE_W +: ANGLE_W] <= raw_angle;
                            ch_delta[c*ANGLE_W +: ANGLE_W] <= ch_valid[c] ?
                                raw_angle - ch_angle[c*ANGLE_W +: ANGLE_W] : '0;
                            ch_valid[c]   <= 1'b1;
                            ch_timeout[c] <= 1'b0;
                        end
                    end
                    sample_stb <= 1'b1;
                    sample_ch  <= ptr_q;
                    state_q    <= StNext;
                end
                StNext: begin
                    if (|ch_mask) begin
                        ptr_q <= next_ch;
                    end
                    if (!enable || !(|ch_mask)) begin
                        state_q <= StIdle;
                    end else begin
                        mux_sel  <= next_ch;
                        settle_q <= '0;
                        state_q  <= StSelect;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
